// File: rtl/running_mean_arbiter.sv
// Round-robin arbiter sharing one running-mean unit between N_LANES top-k lanes.
// Optional feature macro: PRUNE_THRESH_EN adds a registered, saturated prune threshold.
module running_mean_arbiter #(
    parameter int unsigned N_LANES      = 4,
    parameter int unsigned B            = 16,
    parameter int unsigned W            = 10,
    parameter int unsigned WARMUP       = 8,
    parameter int unsigned MARGIN_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [N_LANES-1:0]             lane_valid,
    input  logic [N_LANES*B-1:0]           lane_dist,
    output logic [N_LANES-1:0]             lane_ready,
    output logic                           rm_top_k_done,
    output logic [B-1:0]                   rm_kth_distance,
    output logic                           rm_clr,
    input  logic [B-1:0]                   rm_mean_in,
`ifdef PRUNE_THRESH_EN
    output logic [B-1:0]                   prune_thresh,
    output logic                           prune_thresh_valid,
`endif
    output logic [$clog2(N_LANES)-1:0]     grant_id,
    output logic [W-1:0]                   upd_count,
    output logic                           mean_valid
);

    localparam int unsigned PTR_W = $clog2(N_LANES);

    logic [N_LANES-1:0] buf_v;
    logic [B-1:0]       buf_d [N_LANES];
    logic [PTR_W-1:0]   rr_ptr;

    logic [N_LANES-1:0] gnt_c;
    logic [N_LANES-1:0] hs_c;
    logic               gnt_any_c;
    logic [PTR_W-1:0]   gnt_idx_c;
    logic [PTR_W-1:0]   rr_nxt_c;
    logic [W-1:0]       upd_nxt_c;

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        gnt_c     = '0;
        if (!flush) begin
            for (int k = int'(N_LANES) - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= int'(N_LANES)) begin
                    idx = idx - int'(N_LANES);
                end
                if (buf_v[PTR_W'(idx)]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = PTR_W'(idx);
                end
            end
        end
        if (gnt_any_c) begin
            gnt_c[gnt_idx_c] = 1'b1;
        end
    end

    always_comb begin
        rr_nxt_c   = (gnt_idx_c == PTR_W'(N_LANES - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
        upd_nxt_c  = (&upd_count) ? upd_count : upd_count + W'(1);
        lane_ready = ~{N_LANES{flush}} & (~buf_v | gnt_c);
        hs_c       = lane_valid & lane_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v           <= '0;
            rr_ptr          <= '0;
            upd_count       <= '0;
            mean_valid      <= 1'b0;
            rm_top_k_done   <= 1'b0;
            rm_kth_distance <= '0;
            grant_id        <= '0;
            rm_clr          <= 1'b0;
            for (int i = 0; i < int'(N_LANES); i++) begin
                buf_d[i] <= '0;
            end
        end else if (flush) begin
            buf_v         <= '0;
            rr_ptr        <= '0;
            upd_count     <= '0;
            mean_valid    <= 1'b0;
            rm_top_k_done <= 1'b0;
            rm_clr        <= 1'b1;
        end else begin
            rm_clr        <= 1'b0;
            buf_v         <= (buf_v & ~gnt_c) | hs_c;
            rm_top_k_done <= gnt_any_c;
            for (int i = 0; i < int'(N_LANES); i++) begin
                if (hs_c[i]) begin
                    buf_d[i] <= lane_dist[i*B +: B];
                end
            end
            // Granted lane's old value is read here while its new value loads above.
            if (gnt_any_c) begin
                rm_kth_distance <= buf_d[gnt_idx_c];
                grant_id        <= gnt_idx_c;
                rr_ptr          <= rr_nxt_c;
                upd_count       <= upd_nxt_c;
                mean_valid      <= (upd_nxt_c >= W'(WARMUP));
            end
        end
    end

`ifdef PRUNE_THRESH_EN
    logic [B:0] prune_sum_c;

    always_comb begin
        prune_sum_c = {1'b0, rm_mean_in} + {1'b0, rm_mean_in >> MARGIN_SHIFT};
    end

    // Threshold saturates at all-ones when the margin overflows B bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prune_thresh       <= '0;
            prune_thresh_valid <= 1'b0;
        end else if (flush) begin
            prune_thresh       <= '0;
            prune_thresh_valid <= 1'b0;
        end else begin
            prune_thresh       <= prune_sum_c[B] ? {B{1'b1}} : prune_sum_c[B-1:0];
            prune_thresh_valid <= mean_valid;
        end
    end
`else
    logic unused_mean_c;
    assign unused_mean_c = ^rm_mean_in;
`endif

endmodule
